// File: rtl/led_pwm_multi.sv
// Multi-channel LED PWM dimmer with per-channel duty ramping.
//
// led_pwm_ch    : one LED channel. It holds the duty register, the breathe
//                 direction flag and the registered active-low LED drive.
// led_pwm_multi : the top level. It holds the shared PWM counter and the
//                 duty-step prescaler, plus an array of channel instances.
//
// Ports (top)
//   clk     in   sole clock, rising edge
//   rst_n   in   synchronous active-low reset
//   enable  in   [NUM_CH]        per-channel run/light enable
//   clear   in   [NUM_CH]        per-channel synchronous duty clear
//   mode    in   [2*NUM_CH]      per-channel mode: 00 hold, 01 up, 10 down, 11 breathe
//   led_n   out  [NUM_CH]        active-low LED drive, registered
//   duty    out  [CNT_W*NUM_CH]  per-channel duty value
//   tick    out                  one-clock duty-step pulse

module led_pwm_ch #(
  parameter int CNT_W    = 8,
  parameter int DUTY_MAX = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] pwm_i,
  output logic             led_n_o,
  output logic [CNT_W-1:0] duty_o
);
  localparam logic [CNT_W-1:0] MAXV = CNT_W'(DUTY_MAX - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] duty_q, duty_d;
  logic             dir_q, dir_d;
  logic             led_n_q;

  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    if (duty_q > MAXV) begin
      // Out-of-range value: recover to zero on the next step.
      duty_d = '0;
    end else begin
      unique case (mode_i)
        2'b01: duty_d = (duty_q == MAXV) ? '0 : duty_q + ONE;
        2'b10: duty_d = (duty_q == '0) ? MAXV : duty_q - ONE;
        2'b11: begin
          // At either end the bounce direction wins over a stale flag.
          if (duty_q == MAXV) begin
            duty_d = duty_q - ONE;
            dir_d  = 1'b0;
          end else if (duty_q == '0) begin
            duty_d = duty_q + ONE;
            dir_d  = 1'b1;
          end else if (dir_q) begin
            duty_d = duty_q + ONE;
            if (duty_d == MAXV) dir_d = 1'b0;
          end else begin
            duty_d = duty_q - ONE;
            if (duty_d == '0) dir_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q  <= '0;
      dir_q   <= 1'b1;
      led_n_q <= 1'b1;
    end else begin
      led_n_q <= ~(en_i && (duty_q > pwm_i));
      if (clr_i) begin
        duty_q <= '0;
        dir_q  <= 1'b1;
      end else if (tick_i && en_i) begin
        duty_q <= duty_d;
        dir_q  <= dir_d;
      end
    end
  end

  assign led_n_o = led_n_q;
  assign duty_o  = duty_q;
endmodule

module led_pwm_multi #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int DUTY_MAX = 200,
  parameter int STEP_DIV = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [2*NUM_CH-1:0]     mode,
  output logic [NUM_CH-1:0]       led_n,
  output logic [CNT_W*NUM_CH-1:0] duty,
  output logic                    tick
);
  localparam int               PW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0]    PMAX = PW'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] MAXV = CNT_W'(DUTY_MAX - 1);

  logic [CNT_W-1:0] pwm_q, pwm_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q;

  always_comb begin
    pwm_d   = (pwm_q == MAXV) ? '0 : pwm_q + CNT_W'(1);
    presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
  end

  // tick is registered from the next prescaler value, so it is high exactly
  // while presc_q sits at STEP_DIV-1. It stays low in reset, even when
  // STEP_DIV is 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q   <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      pwm_q   <= pwm_d;
      presc_q <= presc_d;
      tick_q  <= (presc_d == PMAX);
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_pwm_ch #(.CNT_W(CNT_W), .DUTY_MAX(DUTY_MAX)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_i  (tick_q),
      .en_i    (enable[i]),
      .clr_i   (clear[i]),
      .mode_i  (mode[2*i +: 2]),
      .pwm_i   (pwm_q),
      .led_n_o (led_n[i]),
      .duty_o  (duty[CNT_W*i +: CNT_W])
    );
  end
endmodule

// File: tb/tb_led_pwm_multi.sv
// Directed bench for led_pwm_multi with NUM_CH=2, DUTY_MAX=4, STEP_DIV=2.
module tb_led_pwm_multi;
  localparam int NUM_CH = 2, CNT_W = 8, DUTY_MAX = 4, STEP_DIV = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       enable, clear, led_n;
  logic [2*NUM_CH-1:0]     mode;
  logic [CNT_W*NUM_CH-1:0] duty;
  logic                    tick;

  int n_chk = 0, n_pass = 0;

  led_pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DUTY_MAX(DUTY_MAX), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .mode(mode),
    .led_n(led_n), .duty(duty), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic int d0(); return int'(duty[CNT_W-1:0]); endfunction
  function automatic int d1(); return int'(duty[2*CNT_W-1:CNT_W]); endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // Hold reset for two edges, then release it 1 time unit after an edge.
  task automatic do_reset(input logic [2*NUM_CH-1:0] m);
    rst_n = 1'b0; enable = '1; clear = '0; mode = m;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Advance until a tick cycle has been seen, then step past the update edge.
  task automatic next_tick();
    int n = 0;
    while (!tick && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("tick_seen", int'(tick), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_up[5]   = '{1, 2, 3, 0, 1};
    int exp_dn[5]   = '{3, 2, 1, 0, 3};
    int exp_br_a[3] = '{1, 2, 3};
    int exp_br_b[4] = '{2, 1, 0, 1};
    int lows;

    // Reset state, first tick timing, then UP on both channels.
    do_reset(4'b0101);
    chk("rst_duty", int'(duty), 0);
    chk("rst_led_n", int'(led_n), 3);
    chk("rst_tick", int'(tick), 0);
    @(posedge clk); #1;
    chk("first_tick", int'(tick), 1);
    chk("no_step_yet", d0(), 0);
    @(posedge clk); #1;
    chk("up0_first", d0(), 1);
    chk("tick_pulse_end", int'(tick), 0);
    for (int k = 1; k < 5; k++) begin
      next_tick();
      chk("up0", d0(), exp_up[k]);
      chk("up1", d1(), exp_up[k]);
    end

    // Channel 0 DOWN, channel 1 HOLD at zero with its LED dark.
    do_reset(4'b0010);
    for (int k = 0; k < 5; k++) begin
      next_tick();
      chk("dn0", d0(), exp_dn[k]);
      chk("hold1", d1(), 0);
      chk("led1_off", int'(led_n[1]), 1);
    end

    // Channel 0 BREATHE. Park in HOLD at duty 3 and measure one PWM period.
    do_reset(4'b0011);
    for (int k = 0; k < 3; k++) begin
      next_tick();
      chk("br0_up", d0(), exp_br_a[k]);
    end
    mode = 4'b0000;
    @(posedge clk); #1;
    lows = 0;
    for (int c = 0; c < DUTY_MAX; c++) begin
      if (!led_n[0]) lows++;
      @(posedge clk); #1;
    end
    chk("pwm_low_clks", lows, 3);
    chk("held_at_3", d0(), 3);
    mode = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      next_tick();
      chk("br0_bounce", d0(), exp_br_b[k]);
    end

    // A clear that coincides with a tick wins, and only on its own channel.
    do_reset(4'b0101);
    next_tick(); next_tick();
    chk("clr_pre", d0(), 2);
    @(posedge clk); #1;
    chk("clr_on_tick", int'(tick), 1);
    clear = 2'b01;
    @(posedge clk); #1;
    clear = 2'b00;
    chk("clr_duty0", d0(), 0);
    chk("clr_duty1", d1(), 3);

    // Disabling a channel darkens it and freezes its ramp.
    do_reset(4'b0101);
    next_tick(); next_tick();
    enable = 2'b10;
    @(posedge clk); #1;
    chk("dis_led0", int'(led_n[0]), 1);
    next_tick(); next_tick();
    chk("dis_frozen", d0(), 2);
    chk("dis_ch1_runs", d1(), 0);
    enable = 2'b11;
    next_tick();
    chk("reen_resume", d0(), 3);

    // A one-clock reset at the top of a breathe restarts the ramp from zero, going up.
    do_reset(4'b0011);
    next_tick(); next_tick(); next_tick();
    chk("br_top", d0(), 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_duty", int'(duty), 0);
    chk("mid_rst_led_n", int'(led_n), 3);
    chk("mid_rst_tick", int'(tick), 0);
    next_tick();
    chk("post_rst_1", d0(), 1);
    next_tick();
    chk("post_rst_2", d0(), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
